// File: rtl/mpnc_valid_array.sv
// N-read/1-write storage array with per-entry valid bits, single-entry invalidate and a sequential flush sweep.
// Optional macro MPNC_ARRAY_WR_BYPASS_EN forwards a same-cycle write to matching read ports.
//
// state | meaning
// IDLE  | normal operation: writes, invalidates and flush requests accepted
// FLUSH | sweep in progress, one entry zeroed per cycle, writes and invalidates ignored
module mpnc_valid_array #(
    parameter  int WIDTH  = 256,
    parameter  int DEPTH  = 16,
    parameter  int NUM_RD = 2,
    localparam int IDXW   = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load,
    input  logic [IDXW-1:0]                    load_index,
    input  logic [WIDTH-1:0]                   datain,
    output logic                               load_ready,
    input  logic [NUM_RD-1:0][IDXW-1:0]        read_index,
    output logic [NUM_RD-1:0][WIDTH-1:0]       dataout,
    output logic [NUM_RD-1:0]                  valid_out,
    input  logic                               inval,
    input  logic [IDXW-1:0]                    inval_index,
    input  logic                               flush_req,
    output logic                               flush_busy,
    output logic                               flush_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
    localparam logic [IDXW:0]   DEPTH_X  = (IDXW + 1)'(DEPTH);

    state_t             state;
    logic [IDXW-1:0]    ptr;
    logic [DEPTH-1:0]   valid;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic load_ok;
    logic inval_ok;

    assign flush_busy = (state == FLUSH);
    assign load_ready = ~flush_busy;
    assign load_ok    = load & load_ready & ({1'b0, load_index} < DEPTH_X);
    assign inval_ok   = inval & load_ready & ({1'b0, inval_index} < DEPTH_X);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FLUSH;
            ptr        <= '0;
            valid      <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                FLUSH: begin
                    valid[ptr] <= 1'b0;
                    if (ptr == LAST_IDX) begin
                        state      <= IDLE;
                        ptr        <= '0;
                        flush_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    // invalidate first so a same-index load overrides it
                    if (inval_ok) valid[inval_index] <= 1'b0;
                    if (load_ok)  valid[load_index]  <= 1'b1;
                    if (flush_req) begin
                        state <= FLUSH;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; contents are cleared by the sweep that reset starts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == FLUSH) begin
                mem[ptr] <= '0;
            end else if (load_ok) begin
                mem[load_index] <= datain;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            dataout[p]   = '0;
            valid_out[p] = 1'b0;
            if ({1'b0, read_index[p]} < DEPTH_X) begin
                dataout[p]   = mem[read_index[p]];
                valid_out[p] = valid[read_index[p]];
            end
`ifdef MPNC_ARRAY_WR_BYPASS_EN
            if (load_ok && (read_index[p] == load_index)) begin
                dataout[p]   = datain;
                valid_out[p] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mpnc_valid_array.sv
// Self-checking bench for mpnc_valid_array: directed table, flush/reset corner sequences,
// randomized traffic against a behavioural model, and a DEPTH=12 instance for out-of-range indices.
module tb_mpnc_valid_array;

`ifdef MPNC_ARRAY_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int W = 256;
    localparam int D = 16;

    logic              clk;
    logic              reset;
    logic              load;
    logic [3:0]        load_index;
    logic [W-1:0]      datain;
    logic              load_ready;
    logic [1:0][3:0]   read_index;
    logic [1:0][W-1:0] dataout;
    logic [1:0]        valid_out;
    logic              inval;
    logic [3:0]        inval_index;
    logic              flush_req;
    logic              flush_busy;
    logic              flush_done;

    logic              s_reset, s_load, s_ready, s_inval, s_freq, s_busy, s_done;
    logic [3:0]        s_lidx, s_iidx;
    logic [15:0]       s_din;
    logic [1:0][3:0]   s_rd;
    logic [1:0][15:0]  s_dout;
    logic [1:0]        s_vout;

    mpnc_valid_array #(.WIDTH(W), .DEPTH(D), .NUM_RD(2)) dut (
        .clk(clk), .reset(reset), .load(load), .load_index(load_index), .datain(datain),
        .load_ready(load_ready), .read_index(read_index), .dataout(dataout), .valid_out(valid_out),
        .inval(inval), .inval_index(inval_index), .flush_req(flush_req),
        .flush_busy(flush_busy), .flush_done(flush_done)
    );

    mpnc_valid_array #(.WIDTH(16), .DEPTH(12), .NUM_RD(2)) dut12 (
        .clk(clk), .reset(s_reset), .load(s_load), .load_index(s_lidx), .datain(s_din),
        .load_ready(s_ready), .read_index(s_rd), .dataout(s_dout), .valid_out(s_vout),
        .inval(s_inval), .inval_index(s_iidx), .flush_req(s_freq),
        .flush_busy(s_busy), .flush_done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // behavioural model: contents plus remaining sweep length
    logic [W-1:0] m_data [D];
    bit           m_valid [D];
    bit           m_known [D];
    int           m_left = 0;
    bit           m_done = 1'b0;
    bit           m_init = 1'b0;

    logic         obs_busy, obs_done;
    logic [1:0]   obs_valid;
    logic [W-1:0] obs_data0;

    typedef struct {
        bit         ld;
        logic [3:0] li;
        logic [7:0] lb;
        bit         inv;
        logic [3:0] ii;
        logic [3:0] r0;
        logic [3:0] r1;
        logic [1:0] ev;
        logic [7:0] eb;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_model();
        logic [W-1:0] ed;
        bit           ev, ek;
        chk("busy", flush_busy, m_left > 0);
        chk("ready", load_ready, m_left == 0);
        chk("done", flush_done, m_done);
        for (int p = 0; p < 2; p++) begin
            ed = m_data[read_index[p]];
            ev = m_valid[read_index[p]];
            ek = m_known[read_index[p]];
            if (BYP && load && m_left == 0 && read_index[p] == load_index) begin
                ed = datain;
                ev = 1'b1;
                ek = 1'b1;
            end
            chk($sformatf("valid_p%0d", p), valid_out[p], ev);
            if (ek) chk($sformatf("data_p%0d", p), dataout[p], ed);
        end
    endtask

    task automatic model_step();
        int k;
        if (reset) begin
            m_init = 1'b1;
            m_left = D;
            m_done = 1'b0;
            for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (m_left > 0) begin
            k = D - m_left;
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            m_known[k] = 1'b1;
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else begin
            if (inval) m_valid[inval_index] = 1'b0;
            if (load) begin
                m_data[load_index]  = datain;
                m_valid[load_index] = 1'b1;
                m_known[load_index] = 1'b1;
            end
            if (flush_req) m_left = D;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        obs_busy  = flush_busy;
        obs_done  = flush_done;
        obs_valid = valid_out;
        obs_data0 = dataout[0];
        if (m_init) check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; load = 1'b0; inval = 1'b0; flush_req = 1'b0;
        load_index = '0; inval_index = '0; datain = '0; read_index = '0;
    endtask

    task automatic flush_window(input int inj, output int nb, output int nd, output int di);
        nb = 0; nd = 0; di = -1;
        for (int i = 0; i < 24; i++) begin
            if (i == inj) begin
                load = 1'b1; load_index = 4'd2; datain = '1;
            end
            cyc();
            load = 1'b0;
            if (obs_busy) nb++;
            if (obs_done) begin
                nd++;
                if (di < 0) di = i;
            end
        end
    endtask

    initial begin
        int nb, nd, di, pre_done;
        for (int i = 0; i < D; i++) m_known[i] = 1'b0;
        idle_inputs();
        reset = 1'b1;
        s_reset = 1'b1; s_load = 1'b0; s_inval = 1'b0; s_freq = 1'b0;
        s_lidx = '0; s_iidx = '0; s_din = '0; s_rd = '0;

        // reset for one cycle, then a full sweep
        @(posedge clk); #1;
        cyc();
        reset = 1'b0;
        flush_window(-1, nb, nd, di);
        chk("t1_busy_cycles", nb, 16);
        chk("t1_done_pulses", nd, 1);
        chk("t1_done_cycle", di, 16);

        tv[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 4'd0, 4'd1, 2'b00, 8'h00};
        tv[1] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd3, 4'd3, 2'b11, 8'hA5};
        tv[2] = '{1'b1, 4'd5, 8'h5A, 1'b1, 4'd5, 4'd3, 4'd0, 2'b01, 8'hA5};
        tv[3] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd5, 4'd5, 2'b11, 8'h5A};
        tv[4] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 4'd3, 4'd4, 2'b01, 8'hA5};
        tv[5] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd5, 4'd3, 2'b10, 8'h5A};
        tv[6] = '{1'b1, 4'd9, 8'hC3, 1'b1, 4'd3, 4'd5, 4'd9, 2'b00, 8'h5A};
        tv[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd9, 4'd3, 2'b01, 8'hC3};
        for (int i = 0; i < 8; i++) begin
            load = tv[i].ld; load_index = tv[i].li; datain = {32{tv[i].lb}};
            inval = tv[i].inv; inval_index = tv[i].ii;
            read_index[0] = tv[i].r0; read_index[1] = tv[i].r1;
            cyc();
            chk($sformatf("tv%0d_valid", i), obs_valid, tv[i].ev);
            chk($sformatf("tv%0d_data", i), obs_data0, {32{tv[i].eb}});
        end
        idle_inputs();

        // load and flush_req together: write lands, then the sweep clears it
        load = 1'b1; load_index = 4'd7; datain = {32{8'h3C}}; flush_req = 1'b1;
        read_index[0] = 4'd7; read_index[1] = 4'd7;
        cyc();
        load = 1'b0; flush_req = 1'b0;
        cyc();
        chk("t4_first_sweep_valid", obs_valid, 2'b11);
        chk("t4_first_sweep_busy", obs_busy, 1'b1);
        flush_window(2, nb, nd, di);
        chk("t4_busy_cycles", nb, 15);
        chk("t4_done_pulses", nd, 1);
        chk("t4_done_cycle", di, 15);
        read_index[0] = 4'd2; read_index[1] = 4'd7;
        cyc();
        chk("t4_after_valid", obs_valid, 2'b00);

        // reset in the middle of a sweep restarts it
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        pre_done = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (obs_done) pre_done++;
        end
        reset = 1'b1;
        cyc();
        if (obs_done) pre_done++;
        reset = 1'b0;
        chk("t5_no_early_done", pre_done, 0);
        flush_window(-1, nb, nd, di);
        chk("t5_busy_cycles", nb, 16);
        chk("t5_done_pulses", nd, 1);
        chk("t5_done_cycle", di, 16);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            load = $urandom_range(0, 1);
            load_index = 4'($urandom_range(0, 15));
            for (int w = 0; w < 8; w++) datain[w*32 +: 32] = $urandom;
            inval = ($urandom_range(0, 3) == 0);
            inval_index = 4'($urandom_range(0, 15));
            flush_req = ($urandom_range(0, 59) == 0);
            read_index[0] = 4'($urandom_range(0, 15));
            read_index[1] = ($urandom_range(0, 3) == 0) ? load_index : 4'($urandom_range(0, 15));
            cyc();
        end
        idle_inputs();

        // DEPTH=12 instance: out-of-range indices and forwarding
        @(posedge clk); #1;
        s_reset = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!s_busy) break;
            nb++;
            @(posedge clk); #1;
        end
        chk("d12_busy_cycles", nb, 12);
        @(posedge clk); #1;
        s_load = 1'b1; s_lidx = 4'd13; s_din = 16'hBEEF; s_rd[0] = 4'd13; s_rd[1] = 4'd13;
        s_inval = 1'b1; s_iidx = 4'd14;
        @(negedge clk);
        chk("d12_oor_read_valid", s_vout, 2'b00);
        chk("d12_oor_read_data", s_dout[0], 16'h0);
        @(posedge clk); #1;
        s_load = 1'b0; s_inval = 1'b0; s_rd[0] = 4'd13; s_rd[1] = 4'd0;
        @(negedge clk);
        chk("d12_oor_after_valid", s_vout, 2'b00);
        chk("d12_oor_after_data", s_dout[0], 16'h0);
        chk("d12_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        s_load = 1'b1; s_lidx = 4'd2; s_din = 16'h1234; s_rd[0] = 4'd2; s_rd[1] = 4'd2;
        @(negedge clk);
        chk("d12_fwd_data", s_dout[0], BYP ? 16'h1234 : 16'h0);
        chk("d12_fwd_valid", s_vout, BYP ? 2'b11 : 2'b00);
        @(posedge clk); #1;
        s_load = 1'b0;
        @(negedge clk);
        chk("d12_written_data", s_dout[1], 16'h1234);
        chk("d12_written_valid", s_vout, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
